// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath: apple spawn FSM states,
// slot identifiers and board/table dimensions.
package snake_pkg;

   localparam int MAX_LENGTH = 30;
   localparam int NUM_WALLS  = 25;
   localparam int IDX_W      = 5;
   localparam logic [7:0] EMPTY_CELL = 8'h00;

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      LOAD,
      BODY,
      WALL,
      RETRY,
      COMMIT
   } spawn_state_t;

   typedef enum logic {
      SLOT1 = 1'b0,
      SLOT2 = 1'b1
   } slot_t;

   // Body length register is 5 bits but the table only holds MAX_LENGTH entries.
   function automatic logic [IDX_W-1:0] clamp_len(input logic [4:0] len);
      return (len > 5'(MAX_LENGTH)) ? 5'(MAX_LENGTH) : len;
   endfunction

endpackage

// File: rtl/apple_occupancy_scan.sv
// Serial occupancy checker: walks the snake body table or the wall table one entry
// per cycle and flags when the current entry holds the candidate cell.
module apple_occupancy_scan
   import snake_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    step,
   input  logic                    wall_mode,
   input  logic [7:0]              cand,
   input  logic [IDX_W-1:0]        body_len,
   input  logic [MAX_LENGTH*4-1:0] snake_x,
   input  logic [MAX_LENGTH*4-1:0] snake_y,
   input  logic [NUM_WALLS*8-1:0]  walls,
   output logic                    match,
   output logic                    last
);

   logic [IDX_W-1:0] idx;
   logic [7:0]       body_cell;
   logic [7:0]       wall_cell;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
      end else if (start) begin
         idx <= '0;
      end else if (step) begin
         idx <= idx + 1'b1;
      end
   end

   always_comb begin
      body_cell = EMPTY_CELL;
      wall_cell = EMPTY_CELL;
      for (int i = 0; i < MAX_LENGTH; i++) begin
         if (idx == IDX_W'(i)) body_cell = {snake_y[4*i +: 4], snake_x[4*i +: 4]};
      end
      for (int j = 0; j < NUM_WALLS; j++) begin
         if (idx == IDX_W'(j)) wall_cell = walls[8*j +: 8];
      end
   end

   // Empty wall slots still take their cycle but can never match.
   always_comb begin
      if (wall_mode) begin
         match = (wall_cell != EMPTY_CELL) && (wall_cell == cand);
         last  = (idx == IDX_W'(NUM_WALLS - 1));
      end else begin
         match = (body_cell == cand);
         last  = (idx == body_len - 1'b1);
      end
   end

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer: arbitrates spawn requests for both apple slots, draws
// candidate cells from the shared random source and retries until a free cell is found.
module apple_spawn_ctrl
   import snake_pkg::*;
#(
   parameter int         MAX_TRIES = 16,
   parameter logic [7:0] INIT_LOC  = 8'h55
) (
   input  logic                    system_clk,
   input  logic                    reset,
   input  logic                    req1,
   input  logic                    req2,
   input  logic                    two_apple_en,
   input  logic [7:0]              rand_num,
   input  logic [3:0]              xmin,
   input  logic [3:0]              xmax,
   input  logic [3:0]              ymin,
   input  logic [3:0]              ymax,
   input  logic [4:0]              snake_len,
   input  logic [MAX_LENGTH*4-1:0] snakeArrayX,
   input  logic [MAX_LENGTH*4-1:0] snakeArrayY,
   input  logic [NUM_WALLS*8-1:0]  wall_locations,
   output logic                    rand_en,
   output logic [7:0]              apple_location1,
   output logic [7:0]              apple_location2,
   output logic                    busy,
   output logic                    done,
   output logic                    fail
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

   spawn_state_t     state;
   slot_t            granted;
   slot_t            last_slot;
   slot_t            grant_sel;
   logic             pend1;
   logic             pend2;
   logic [TRY_W-1:0] tries;
   logic [7:0]       cand;

   logic [IDX_W-1:0] body_len;
   logic             pend2_live;
   logic             grant_any;
   logic             serve1;
   logic             serve2;
   logic             in_bounds;
   logic             other_hit;
   logic             reject;
   logic             scan_start;
   logic             scan_step;
   logic             scan_match;
   logic             scan_last;

   assign body_len = clamp_len(snake_len);

   // Round-robin between slots; a slot being granted or in service swallows its own requests.
   always_comb begin
      pend2_live = pend2 && two_apple_en;
      grant_any  = (state == IDLE) && (pend1 || pend2_live);
      if (pend1 && pend2_live) grant_sel = (last_slot == SLOT1) ? SLOT2 : SLOT1;
      else                     grant_sel = pend1 ? SLOT1 : SLOT2;
      serve1 = ((state != IDLE) && (granted == SLOT1)) || (grant_any && (grant_sel == SLOT1));
      serve2 = ((state != IDLE) && (granted == SLOT2)) || (grant_any && (grant_sel == SLOT2));
   end

   always_comb begin
      in_bounds = (rand_num[3:0] >= xmin) && (rand_num[3:0] <= xmax) &&
                  (rand_num[7:4] >= ymin) && (rand_num[7:4] <= ymax);
      if (granted == SLOT1) other_hit = two_apple_en && (rand_num == apple_location2);
      else                  other_hit = (rand_num == apple_location1);
      reject = ((state == LOAD) && (!in_bounds || other_hit)) ||
               (((state == BODY) || (state == WALL)) && scan_match);
      scan_start = (state == LOAD) || ((state == BODY) && scan_last && !scan_match);
      scan_step  = (state == BODY) || (state == WALL);
   end

   apple_occupancy_scan u_scan (
      .clk       (system_clk),
      .reset     (reset),
      .start     (scan_start),
      .step      (scan_step),
      .wall_mode (state == WALL),
      .cand      (cand),
      .body_len  (body_len),
      .snake_x   (snakeArrayX),
      .snake_y   (snakeArrayY),
      .walls     (wall_locations),
      .match     (scan_match),
      .last      (scan_last)
   );

   always_ff @(posedge system_clk) begin
      if (state == LOAD) cand <= rand_num;
   end

   always_ff @(posedge system_clk) begin
      if (reset) begin
         state           <= IDLE;
         granted         <= SLOT1;
         last_slot       <= SLOT2;
         pend1           <= 1'b0;
         pend2           <= 1'b0;
         tries           <= '0;
         apple_location1 <= INIT_LOC;
         apple_location2 <= two_apple_en ? INIT_LOC : EMPTY_CELL;
         rand_en         <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         fail            <= 1'b0;
      end else begin
         rand_en <= 1'b0;
         done    <= 1'b0;
         fail    <= 1'b0;
         pend1   <= (pend1 && !(grant_any && (grant_sel == SLOT1))) || (req1 && !serve1);
         pend2   <= two_apple_en &&
                    ((pend2 && !(grant_any && (grant_sel == SLOT2))) || (req2 && !serve2));

         if (reject) begin
            state <= RETRY;
            fail  <= (tries == LAST_TRY);
         end else begin
            case (state)
               IDLE: begin
                  if (grant_any) begin
                     granted <= grant_sel;
                     tries   <= '0;
                     state   <= DRAW;
                     rand_en <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
               DRAW:  state <= LOAD;
               LOAD:  state <= (body_len == '0) ? WALL : BODY;
               BODY:  if (scan_last) state <= WALL;
               WALL: begin
                  if (scan_last) begin
                     state <= COMMIT;
                     done  <= 1'b1;
                  end
               end
               RETRY: begin
                  if (tries == LAST_TRY) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     last_slot <= granted;
                  end else begin
                     tries   <= tries + 1'b1;
                     state   <= DRAW;
                     rand_en <= 1'b1;
                  end
               end
               COMMIT: begin
                  if (granted == SLOT1) apple_location1 <= cand;
                  else                  apple_location2 <= cand;
                  state     <= IDLE;
                  busy      <= 1'b0;
                  last_slot <= granted;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end

         if (!two_apple_en) apple_location2 <= EMPTY_CELL;
      end
   end

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Scoreboard bench for apple_spawn_ctrl: a cell-level reference model predicts each
// request's outcome, draw count and committed location; a monitor checks them.
module tb_apple_spawn_ctrl;
   import snake_pkg::*;

   localparam int MT = 16;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    req1 = 1'b0;
   logic                    req2 = 1'b0;
   logic                    en = 1'b1;
   logic [7:0]              rand_num = 8'h00;
   logic [3:0]              xmin, xmax, ymin, ymax;
   logic [4:0]              snake_len;
   logic [MAX_LENGTH*4-1:0] sx, sy;
   logic [NUM_WALLS*8-1:0]  walls;
   logic                    rand_en, busy, done, fail;
   logic [7:0]              loc1, loc2;

   always #5 clk = ~clk;

   apple_spawn_ctrl dut (
      .system_clk      (clk),
      .reset           (reset),
      .req1            (req1),
      .req2            (req2),
      .two_apple_en    (en),
      .rand_num        (rand_num),
      .xmin            (xmin),
      .xmax            (xmax),
      .ymin            (ymin),
      .ymax            (ymax),
      .snake_len       (snake_len),
      .snakeArrayX     (sx),
      .snakeArrayY     (sy),
      .wall_locations  (walls),
      .rand_en         (rand_en),
      .apple_location1 (loc1),
      .apple_location2 (loc2),
      .busy            (busy),
      .done            (done),
      .fail            (fail)
   );

   typedef struct {
      bit         is_fail;
      bit         slot2;
      logic [7:0] loc;
      int         pulses;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] draw_q[$];
   logic [3:0] bx[MAX_LENGTH];
   logic [3:0] by[MAX_LENGTH];
   logic [7:0] wl[NUM_WALLS];
   logic [7:0] plan_draws[MT];
   logic [7:0] m_loc1, m_loc2;
   bit         m_last2;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         pulse_cnt = 0;
   int         last_ev_cyc = 0;
   int         t_issue = 0;
   bit         prev_ren = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_env();
      for (int i = 0; i < MAX_LENGTH; i++) begin
         sx[4*i +: 4] = bx[i];
         sy[4*i +: 4] = by[i];
      end
      for (int j = 0; j < NUM_WALLS; j++) walls[8*j +: 8] = wl[j];
   endtask

   // A cell is usable if it is inside the box, not the other apple, not body, not wall.
   function automatic bit cell_free(input bit s2, input logic [7:0] d);
      int len;
      len = int'(snake_len);
      if (len > MAX_LENGTH) len = MAX_LENGTH;
      if (d[3:0] < xmin || d[3:0] > xmax || d[7:4] < ymin || d[7:4] > ymax) return 1'b0;
      if (s2 ? (d == m_loc1) : (en && d == m_loc2)) return 1'b0;
      for (int i = 0; i < len; i++) if ({by[i], bx[i]} == d) return 1'b0;
      for (int j = 0; j < NUM_WALLS; j++) if (wl[j] != 8'h00 && wl[j] == d) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [7:0] pick_draw();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) return {by[$urandom_range(0, MAX_LENGTH-1)], bx[$urandom_range(0, MAX_LENGTH-1)]};
      if (r < 4) return wl[$urandom_range(0, NUM_WALLS-1)];
      if (r == 4 || xmin > xmax || ymin > ymax) return 8'($urandom);
      return {4'($urandom_range(int'(ymin), int'(ymax))), 4'($urandom_range(int'(xmin), int'(xmax)))};
   endfunction

   task automatic make_draws();
      for (int k = 0; k < MT; k++) plan_draws[k] = pick_draw();
   endtask

   // Predict one serviced request: the first usable draw wins, else the slot gives up.
   task automatic plan(input bit s2);
      exp_t e;
      bit   found;
      found     = 1'b0;
      e.slot2   = s2;
      e.is_fail = 1'b1;
      e.pulses  = MT;
      e.loc     = s2 ? m_loc2 : m_loc1;
      for (int k = 0; k < MT; k++) begin
         if (!found && cell_free(s2, plan_draws[k])) begin
            found     = 1'b1;
            e.is_fail = 1'b0;
            e.pulses  = k + 1;
            e.loc     = plan_draws[k];
         end
      end
      for (int k = 0; k < e.pulses; k++) draw_q.push_back(plan_draws[k]);
      sb.push_back(e);
      if (!e.is_fail) begin
         if (s2) m_loc2 = e.loc;
         else    m_loc1 = e.loc;
      end
      m_last2 = s2;
   endtask

   task automatic issue(input bit r1, input bit r2);
      @(negedge clk);
      req1 = r1;
      req2 = r2;
      t_issue = cyc;
      @(negedge clk);
      req1 = 1'b0;
      req2 = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sb.size() != 0 || busy) && k < 4000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 4000) check("idle_timeout", k, 0);
      tick(2);
   endtask

   task automatic model_reset();
      draw_q.delete();
      sb.delete();
      pulse_cnt = 0;
      m_loc1    = 8'h55;
      m_loc2    = en ? 8'h55 : 8'h00;
      m_last2   = 1'b1;
   endtask

   // Random source driver and output monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rand_en) begin
            check("rand_en_width", int'(prev_ren), 0);
            pulse_cnt++;
            if (draw_q.size() > 0) rand_num = draw_q.pop_front();
            else begin
               check("draw_available", 0, 1);
               rand_num = 8'($urandom);
            end
         end
         prev_ren = rand_en;
         if (!reset && (done || fail)) begin
            last_ev_cyc = cyc;
            if (sb.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               e = sb.pop_front();
               check("outcome_done", int'(done), int'(!e.is_fail));
               check("outcome_fail", int'(fail), int'(e.is_fail));
               check("rand_en_pulses", pulse_cnt, e.pulses);
               pulse_cnt = 0;
               @(posedge clk);
               #1;
               check(e.slot2 ? "apple_location2" : "apple_location1",
                     int'(e.slot2 ? loc2 : loc1), int'(e.loc));
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         first2;
      logic [7:0] old;
      logic [7:0] v;
      int         seen;

      xmin = 4'h0; xmax = 4'hF; ymin = 4'h0; ymax = 4'hF;
      snake_len = 5'd3;
      for (int i = 0; i < MAX_LENGTH; i++) begin
         bx[i] = 4'(i);
         by[i] = 4'hE;
      end
      for (int j = 0; j < NUM_WALLS; j++) wl[j] = 8'h00;
      drive_env();
      model_reset();

      tick(3);
      check("reset_busy", int'(busy), 0);
      check("reset_rand_en", int'(rand_en), 0);
      check("reset_done", int'(done), 0);
      check("reset_fail", int'(fail), 0);
      check("reset_loc1", int'(loc1), 8'h55);
      check("reset_loc2", int'(loc2), 8'h55);
      reset = 1'b0;
      tick(2);

      // Single request, first draw free: fixed latency.
      make_draws();
      plan_draws[0] = 8'h34;
      plan(1'b0);
      issue(1'b1, 1'b0);
      wait_idle();
      check("latency_no_retry", last_ev_cyc - t_issue, 32);

      // Simultaneous requests right after reset: slot 1 first.
      @(negedge clk); reset = 1'b1;
      tick(2); reset = 1'b0;
      model_reset();
      first2 = !m_last2;
      make_draws(); plan(first2);
      make_draws(); plan(!first2);
      issue(1'b1, 1'b1);
      wait_idle();

      // First draw lands on the body, second is free.
      make_draws();
      plan_draws[0] = {by[1], bx[1]};
      plan_draws[1] = 8'h9A;
      plan(1'b0);
      issue(1'b1, 1'b0);
      wait_idle();

      // Inverted x bounds: every draw rejected.
      xmin = 4'h9; xmax = 4'h3;
      make_draws(); plan(1'b0);
      issue(1'b1, 1'b0);
      wait_idle();
      xmin = 4'h0; xmax = 4'hF;

      // Every draw lands on a wall.
      for (int j = 0; j < 8; j++) wl[j] = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
      drive_env();
      for (int k = 0; k < MT; k++) plan_draws[k] = wl[k % 8];
      plan(1'b1);
      issue(1'b0, 1'b1);
      wait_idle();
      for (int j = 0; j < NUM_WALLS; j++) wl[j] = 8'h00;
      drive_env();

      // Candidate on apple 2 rejected while enabled, accepted once slot 2 is disabled.
      old = m_loc2;
      make_draws();
      plan_draws[0] = old;
      plan(1'b0);
      issue(1'b1, 1'b0);
      wait_idle();
      @(negedge clk); en = 1'b0; m_loc2 = 8'h00;
      @(negedge clk);
      check("loc2_forced_zero", int'(loc2), 0);
      make_draws();
      plan_draws[0] = old;
      plan(1'b0);
      issue(1'b1, 1'b0);
      wait_idle();
      issue(1'b0, 1'b1);
      tick(4);
      check("req2_ignored_disabled", int'(busy), 0);
      @(negedge clk); en = 1'b1;

      // Reset in the middle of a body scan.
      snake_len = 5'd30;
      v = 8'h77;
      while (v == m_loc1 || v == m_loc2) v = v + 8'h01;
      draw_q.push_back(v);
      issue(1'b1, 1'b1);
      tick(6);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_busy", int'(busy), 0);
      check("midreset_loc1", int'(loc1), 8'h55);
      check("midreset_done", int'(done), 0);
      reset = 1'b0;
      model_reset();
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (busy || done || rand_en) seen++;
      end
      check("midreset_pending_cleared", seen, 0);

      // Randomized environments and request patterns.
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            xmin = 4'($urandom_range(8, 15));
            xmax = 4'($urandom_range(0, int'(xmin) - 1));
         end else begin
            xmin = 4'($urandom_range(0, 4));
            xmax = 4'($urandom_range(9, 15));
         end
         ymin = 4'($urandom_range(0, 4));
         ymax = 4'($urandom_range(9, 15));
         snake_len = 5'($urandom_range(0, 31));
         for (int i = 0; i < MAX_LENGTH; i++) begin
            bx[i] = 4'($urandom);
            by[i] = 4'($urandom);
         end
         for (int j = 0; j < NUM_WALLS; j++) wl[j] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         drive_env();
         if ($urandom_range(0, 4) == 0) begin
            en = 1'b0;
            m_loc2 = 8'h00;
         end else begin
            en = 1'b1;
         end
         case ($urandom_range(0, 2))
            0: begin
               make_draws(); plan(1'b0);
               issue(1'b1, 1'b0);
            end
            1: begin
               make_draws(); plan(en);
               issue(!en, en);
            end
            default: begin
               if (en) begin
                  first2 = !m_last2;
                  make_draws(); plan(first2);
                  make_draws(); plan(!first2);
                  issue(1'b1, 1'b1);
               end else begin
                  make_draws(); plan(1'b0);
                  issue(1'b1, 1'b0);
               end
            end
         endcase
         wait_idle();
      end

      check("draw_queue_drained", draw_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
